angle_setpoint_ctrl: RTL and testbench



---
 rtl/angle_ctrl_pkg.sv | 37 +++
 rtl/key_debounce.sv | 50 +++++
 rtl/angle_setpoint_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_angle_setpoint_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/angle_ctrl_pkg.sv
// Shared types and helpers for the angle setpoint controller.
// Combinational only, no latency, no backpressure.
// rpt_state_t is consumed only when ANGLE_AUTO_REPEAT_EN is defined.
package angle_ctrl_pkg;

  localparam int BCD_W    = 12;
  localparam int SW_MAX   = 32;
  localparam int SW_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  typedef struct packed {
    logic                valid;
    logic [SW_IDX_W-1:0] idx;
  } sel_t;

  // valid only for exactly one set bit; idx is the highest set bit
  function automatic sel_t onehot_check(input logic [SW_MAX-1:0] sw);
    sel_t        r;
    int unsigned cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < SW_MAX; i++) begin
      if (sw[i]) begin
        cnt++;
        r.idx = SW_IDX_W'(i);
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF synchroniser, restartable debounce counter, committed level, rise pulse.
// Latency raw->level = 2 + DEBOUNCE_CYC cycles; rise pulses with the committing edge.
// No backpressure; a key held through reset must be released before it can rise again.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic             s1;
  logic             s2;
  logic [1:0]       flush;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      flush <= '0;
      armed <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      flush <= {flush[0], 1'b1};
      rise  <= 1'b0;
      // only arm once the synchroniser holds a real sample that reads released
      if (flush[1] && !s2) armed <= 1'b1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        cnt   <= '0;
        level <= s2;
        rise  <= s2 & armed;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/angle_setpoint_ctrl.sv
// Multi-channel saturating angle setpoints stepped by debounced keys; optional ANGLE_AUTO_REPEAT_EN.
// Latency raw key -> register/upd = 3 + DEBOUNCE_CYC cycles; sel_angle/sel_bcd combinational.
// No backpressure; presses while the selection is invalid or the other key is held are dropped.
module angle_setpoint_ctrl
  import angle_ctrl_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int ANGLE_W      = 8,
  parameter int ANGLE_MIN    = 0,
  parameter int ANGLE_MAX    = 180,
  parameter int ANGLE_INIT   = 90,
  parameter int STEP         = 1,
  parameter int DEBOUNCE_CYC = 500000
`ifdef ANGLE_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
`endif
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic                    KEY_UP,
  input  logic                    KEY_DN,
  input  logic [N_CH-1:0]         SW,
  output logic [N_CH*ANGLE_W-1:0] angle_out,
  output logic [ANGLE_W-1:0]      sel_angle,
  output logic                    sel_valid,
  output logic [BCD_W-1:0]        sel_bcd,
  output logic                    upd
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int EXT_W = ANGLE_W + 1;
  localparam logic [EXT_W-1:0]   MAX_X  = EXT_W'(ANGLE_MAX);
  localparam logic [EXT_W-1:0]   MIN_X  = EXT_W'(ANGLE_MIN);
  localparam logic [EXT_W-1:0]   STEP_X = EXT_W'(STEP);
  localparam logic [ANGLE_W-1:0] INIT_V = ANGLE_W'(ANGLE_INIT);

  function automatic logic [BCD_W-1:0] bin2bcd(input logic [ANGLE_W-1:0] v);
    logic [BCD_W-1:0] b;
    b = '0;
    for (int i = ANGLE_W - 1; i >= 0; i--) begin
      for (int d = 0; d < 3; d++) begin
        if (b[d*4 +: 4] >= 4'd5) b[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
      end
      b = {b[BCD_W-2:0], v[i]};
    end
    return b;
  endfunction

  logic                up_lvl, up_rise, dn_lvl, dn_rise;
  logic [N_CH-1:0]     sw_s1, sw_s2;
  sel_t                sel_chk;
  logic [IDX_W-1:0]    sel_idx;
  logic [ANGLE_W-1:0]  angle_q [N_CH];
  logic [EXT_W-1:0]    cur_x, up_x, up_val, dn_val, nxt_x;
  logic                press_up, press_dn, step_up, step_dn, do_wr;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .raw   (KEY_UP),
    .level (up_lvl),
    .rise  (up_rise)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_dn (
    .clk   (CLOCK_50),
    .rst   (RESET),
    .raw   (KEY_DN),
    .level (dn_lvl),
    .rise  (dn_rise)
  );

  assign sel_chk   = onehot_check(SW_MAX'(sw_s2));
  assign sel_valid = sel_chk.valid && ({1'b0, sel_chk.idx} < (SW_IDX_W + 1)'(N_CH));
  assign sel_idx   = sel_chk.idx[IDX_W-1:0];

  // a rising edge counts only while the opposite key is released
  assign press_up = up_rise & ~dn_lvl & sel_valid;
  assign press_dn = dn_rise & ~up_lvl & sel_valid;

`ifdef ANGLE_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  rpt_state_t       state_q, state_d;
  logic             dir_q, dir_d;
  logic [RPT_W-1:0] rcnt_q, rcnt_d;
  logic [N_CH-1:0]  sw_q;
  logic             rpt_step, abort;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rcnt_q  <= '0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rcnt_q  <= rcnt_d;
      sw_q    <= sw_s2;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rcnt_d   = rcnt_q;
    rpt_step = 1'b0;
    abort    = !(dir_q ? up_lvl : dn_lvl) || (up_lvl && dn_lvl) || !sel_valid || (sw_s2 != sw_q);
    case (state_q)
      IDLE: begin
        if (press_up || press_dn) begin
          state_d = HOLD;
          dir_d   = press_up;
          rcnt_d  = '0;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rcnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
          state_d  = REPEAT;
          rcnt_d   = '0;
          rpt_step = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rcnt_q == RPT_W'(REPEAT_RATE - 1)) begin
          rcnt_d   = '0;
          rpt_step = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign step_up = press_up | (rpt_step & dir_q);
  assign step_dn = press_dn | (rpt_step & ~dir_q);
`else
  assign step_up = press_up;
  assign step_dn = press_dn;
`endif

  // one bit of headroom keeps add/subtract from ever wrapping
  always_comb begin
    cur_x  = {1'b0, angle_q[sel_idx]};
    up_x   = cur_x + STEP_X;
    up_val = (up_x > MAX_X) ? MAX_X : up_x;
    dn_val = (cur_x < MIN_X + STEP_X) ? MIN_X : cur_x - STEP_X;
    nxt_x  = step_up ? up_val : (step_dn ? dn_val : cur_x);
    do_wr  = (step_up | step_dn) & (nxt_x != cur_x);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      upd   <= 1'b0;
      for (int i = 0; i < N_CH; i++) angle_q[i] <= INIT_V;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      upd   <= do_wr;
      if (do_wr) angle_q[sel_idx] <= nxt_x[ANGLE_W-1:0];
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign angle_out[g*ANGLE_W +: ANGLE_W] = angle_q[g];
  end

  assign sel_angle = sel_valid ? angle_q[sel_idx] : '0;
  assign sel_bcd   = bin2bcd(sel_angle);

endmodule

// File: tb/tb_angle_setpoint_ctrl.sv
// Bench for angle_setpoint_ctrl: vector table plus hand sequences, scoreboard checked on every upd.
module tb_angle_setpoint_ctrl;

  localparam int NC   = 4;
  localparam int AW   = 8;
  localparam int DB   = 4;
`ifdef ANGLE_AUTO_REPEAT_EN
  localparam int RDELAY   = 20;
  localparam int RRATE    = 5;
  localparam int HOLD_CYC = 50;
`endif

  typedef struct {
    logic [3:0] sw;
    bit         up;
    int         ch;
    int         val;
    int         upd;
    bit         valid;
  } vec_t;

  typedef struct {
    int ch;
    int val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, key_up, key_dn;
  logic [3:0]       sw;
  logic [NC*AW-1:0] angle_out;
  logic [AW-1:0]    sel_angle;
  logic             sel_valid;
  logic [11:0]      sel_bcd;
  logic             upd;

  int   n_checks = 0;
  int   n_errors = 0;
  int   upd_cnt  = 0;
  int   exp_ang [NC];
  exp_t sb_q [$];
  exp_t mon_e;
  vec_t vecs [8];

  angle_setpoint_ctrl #(
    .N_CH(NC), .ANGLE_W(AW), .ANGLE_MIN(0), .ANGLE_MAX(180),
    .ANGLE_INIT(90), .STEP(1), .DEBOUNCE_CYC(DB)
`ifdef ANGLE_AUTO_REPEAT_EN
    , .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
`endif
  ) dut (
    .CLOCK_50  (clk),
    .RESET     (rst),
    .KEY_UP    (key_up),
    .KEY_DN    (key_dn),
    .SW        (sw),
    .angle_out (angle_out),
    .sel_angle (sel_angle),
    .sel_valid (sel_valid),
    .sel_bcd   (sel_bcd),
    .upd       (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up, input int hold, input int rel);
    if (up) key_up = 1'b1;
    else    key_dn = 1'b1;
    cyc(hold);
    key_up = 1'b0;
    key_dn = 1'b0;
    cyc(rel);
  endtask

  task automatic push(input int ch, input int val);
    exp_t e;
    e.ch  = ch;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NC; c++)
      check($sformatf("%s_ch%0d", tag, c), int'(angle_out[c*AW +: AW]), exp_ang[c]);
  endtask

  // every register update must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (upd === 1'b1) begin
      upd_cnt++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_upd: got upd with empty scoreboard, expected none");
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("sb_ch%0d", mon_e.ch), int'(angle_out[mon_e.ch*AW +: AW]), mon_e.val);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 1'b1, 0, 93, 1, 1'b1};
    vecs[1] = '{4'b0001, 1'b0, 0, 92, 1, 1'b1};
    vecs[2] = '{4'b0010, 1'b0, 1, 89, 1, 1'b1};
    vecs[3] = '{4'b1000, 1'b1, 3, 91, 1, 1'b1};
    vecs[4] = '{4'b0110, 1'b1, 1, 89, 0, 1'b0};
    vecs[5] = '{4'b0000, 1'b0, 0, 92, 0, 1'b0};
    vecs[6] = '{4'b1000, 1'b0, 3, 90, 1, 1'b1};
    vecs[7] = '{4'b0010, 1'b1, 1, 90, 1, 1'b1};
    for (int c = 0; c < NC; c++) exp_ang[c] = 90;

    rst = 1'b1; key_up = 1'b0; key_dn = 1'b0; sw = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    check("reset_upd", int'(upd), 0);
    check("reset_sel_valid", int'(sel_valid), 0);
    check("reset_sel_angle", int'(sel_angle), 0);
    check("reset_sel_bcd", int'(sel_bcd), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // clean press: register changes on the 7th edge after the key goes high
    sw = 4'b0001;
    cyc(5);
    upd_cnt = 0;
    exp_ang[0] = 91;
    push(0, 91);
    key_up = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("lat_before_ch0", int'(angle_out[AW-1:0]), 90);
    check("lat_before_upd", int'(upd), 0);
    @(negedge clk);
    check("lat_at_ch0", int'(angle_out[AW-1:0]), 91);
    check("lat_at_upd", int'(upd), 1);
    check("lat_at_bcd", int'(sel_bcd), 'h091);
    check("lat_at_sel", int'(sel_angle), 91);
    cyc(2);
    key_up = 1'b0;
    cyc(10);
    check("clean_upd_cnt", upd_cnt, 1);
    check_all("clean");

    // bouncing key: level toggles every 2 cycles, then settles high
    upd_cnt = 0;
    exp_ang[0] = 92;
    push(0, 92);
    for (int k = 0; k < 12; k++) begin
      key_up = ((k % 4) < 2);
      cyc(1);
    end
    key_up = 1'b1;
    cyc(10);
    key_up = 1'b0;
    cyc(10);
    check("bounce_upd_cnt", upd_cnt, 1);
    check_all("bounce");

    for (int i = 0; i < 8; i++) begin
      sw = vecs[i].sw;
      cyc(4);
      upd_cnt = 0;
      if (vecs[i].upd != 0) push(vecs[i].ch, vecs[i].val);
      press(vecs[i].up, 8, 8);
      check($sformatf("vec%0d_upd_cnt", i), upd_cnt, vecs[i].upd);
      check($sformatf("vec%0d_sel_valid", i), int'(sel_valid), int'(vecs[i].valid));
      check($sformatf("vec%0d_sel_angle", i), int'(sel_angle), vecs[i].valid ? vecs[i].val : 0);
      exp_ang[vecs[i].ch] = vecs[i].val;
      check_all($sformatf("vec%0d", i));
    end

    // saturation at both limits on channel 2
    sw = 4'b0100;
    cyc(4);
    for (int k = 0; k < 90; k++) begin
      exp_ang[2]++;
      push(2, exp_ang[2]);
      press(1'b1, 7, 7);
    end
    upd_cnt = 0;
    press(1'b1, 7, 7);
    check("sat_hi_upd_cnt", upd_cnt, 0);
    check("sat_hi_ch2", int'(angle_out[2*AW +: AW]), 180);
    check("sat_hi_bcd", int'(sel_bcd), 'h180);
    for (int k = 0; k < 180; k++) begin
      exp_ang[2]--;
      push(2, exp_ang[2]);
      press(1'b0, 7, 7);
    end
    upd_cnt = 0;
    press(1'b0, 7, 7);
    check("sat_lo_upd_cnt", upd_cnt, 0);
    check("sat_lo_ch2", int'(angle_out[2*AW +: AW]), 0);
    check("sat_lo_bcd", int'(sel_bcd), 0);
    check_all("sat");

    // KEY_DN held, KEY_UP pressed and released during the overlap
    sw = 4'b0001;
    cyc(4);
    upd_cnt = 0;
    exp_ang[0] = 91;
    push(0, 91);
    key_dn = 1'b1;
    cyc(12);
    key_up = 1'b1;
    cyc(12);
    key_up = 1'b0;
    cyc(10);
    key_dn = 1'b0;
    cyc(10);
    check("overlap_upd_cnt", upd_cnt, 1);
    check_all("overlap");

    // reset while KEY_UP is held
    push(0, 92);
    key_up = 1'b1;
    cyc(10);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    upd_cnt = 0;
    for (int c = 0; c < NC; c++) exp_ang[c] = 90;
    cyc(15);
    check("rstheld_upd_cnt", upd_cnt, 0);
    check_all("rstheld");
    key_up = 1'b0;
    cyc(10);
    check("rstrel_upd_cnt", upd_cnt, 0);
    exp_ang[0] = 91;
    push(0, 91);
    press(1'b1, 7, 7);
    check("repress_upd_cnt", upd_cnt, 1);
    check_all("repress");

`ifdef ANGLE_AUTO_REPEAT_EN
    // hold measured from the raw press to the committed release
    begin
      int n_steps;
      n_steps = 1 + 1 + (HOLD_CYC - 7 - RDELAY) / RRATE;
      sw = 4'b0010;
      cyc(4);
      upd_cnt = 0;
      for (int k = 0; k < n_steps; k++) begin
        exp_ang[1]++;
        push(1, exp_ang[1]);
      end
      key_up = 1'b1;
      cyc(HOLD_CYC - 2 - DB);
      key_up = 1'b0;
      cyc(15);
      check("repeat_upd_cnt", upd_cnt, n_steps);
      check_all("repeat");
    end
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
